// File: rtl/alu_lanes_pkg.sv
// Shared constants, lane vector type, sequencer states and operand-select encodings for the lane ALU sequencer.
// No logic of its own; chunk_addr gives the wrapped element address of chunk k.
package alu_lanes_pkg;

   localparam int WIDTH  = 8;
   localparam int LANES  = 6;
   localparam int MAXLEN = 48;
   localparam int AW     = 6;
   // Chunk index width: MAXLEN/LANES chunks fit in 4 bits
   localparam int KW     = 4;

   typedef logic [LANES-1:0][WIDTH-1:0] lane_vec_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WRITE,
      ST_DONE
   } seq_state_e;

   localparam logic [1:0] VSI_VV = 2'd0;
   localparam logic [1:0] VSI_VS = 2'd1;
   localparam logic [1:0] VSI_VI = 2'd2;

   function automatic logic [AW-1:0] chunk_addr(input logic [AW-1:0] base, input logic [KW-1:0] k);
      return base + AW'(int'(k) * LANES);
   endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// Active-lane mask for chunk k of a len-element command; lane i is active iff k*LANES+i < len.
// Purely combinational, zero latency, no handshake.
module lane_mask_gen
   import alu_lanes_pkg::*;
(
   input  logic [KW-1:0]    k_i,
   input  logic [AW:0]      len_i,
   output logic [LANES-1:0] mask_o
);

   always_comb begin
      mask_o = '0;
      for (int i = 0; i < LANES; i++) begin
         mask_o[i] = (int'(k_i) * LANES + i) < int'(len_i);
      end
   end

endmodule

// File: rtl/alu_lanes_seq.sv
// Walks one vector command through the lane ALU in LANES-element chunks: read, exec, write per chunk, then a done pulse.
// Three cycles per chunk plus one done cycle; commands accepted only when idle, memory never stalls.
module alu_lanes_seq
   import alu_lanes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [2:0]             cmd_op,
   input  logic [1:0]             cmd_vsi,
   input  logic [2:0]             cmd_srcbi,
   input  logic [WIDTH-1:0]       cmd_imm,
   input  logic [AW:0]            cmd_len,
   input  logic [AW-1:0]          cmd_a_base,
   input  logic [AW-1:0]          cmd_b_base,
   input  logic [AW-1:0]          cmd_d_base,
   output logic                   rd_en,
   output logic [AW-1:0]          rd_a_addr,
   output logic [AW-1:0]          rd_b_addr,
   input  logic [LANES*WIDTH-1:0] rd_a_data,
   input  logic [LANES*WIDTH-1:0] rd_b_data,
   output logic [2:0]             alu_op,
   output logic [1:0]             alu_vsi,
   output logic [2:0]             alu_srcbi,
   output logic [WIDTH-1:0]       alu_imm,
   output logic [LANES*WIDTH-1:0] alu_srca,
   output logic [LANES*WIDTH-1:0] alu_srcb,
   input  logic [LANES*WIDTH-1:0] alu_result,
   input  logic [LANES*2-1:0]     alu_flags,
   output logic                   wr_en,
   output logic [AW-1:0]          wr_addr,
   output logic [LANES-1:0]       wr_mask,
   output logic [LANES*WIDTH-1:0] wr_data,
   output logic                   busy,
   output logic                   done,
   output logic [1:0]             flags_acc
);

   seq_state_e       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [1:0]       vsi_q, vsi_d;
   logic [2:0]       srcbi_q, srcbi_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [AW:0]      len_q, len_d;
   logic [AW-1:0]    a_base_q, a_base_d;
   logic [AW-1:0]    b_base_q, b_base_d;
   logic [AW-1:0]    d_base_q, d_base_d;
   logic [KW-1:0]    k_q, k_d;
   lane_vec_t        wr_data_q, wr_data_d;
   logic [1:0]       flags_q, flags_d;

   logic [LANES-1:0] lane_mask;
   logic [1:0]       flag_or;
   logic             last_chunk;
   logic [AW:0]      len_sat;

   lane_mask_gen u_mask (
      .k_i    (k_q),
      .len_i  (len_q),
      .mask_o (lane_mask)
   );

   assign len_sat    = (cmd_len > (AW+1)'(MAXLEN)) ? (AW+1)'(MAXLEN) : cmd_len;
   assign last_chunk = (int'(k_q) + 1) * LANES >= int'(len_q);

   // Flags from lanes past the end of the vector carry garbage and must not stick
   always_comb begin
      flag_or = '0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_mask[i]) flag_or = flag_or | alu_flags[2*i +: 2];
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      vsi_d     = vsi_q;
      srcbi_d   = srcbi_q;
      imm_d     = imm_q;
      len_d     = len_q;
      a_base_d  = a_base_q;
      b_base_d  = b_base_q;
      d_base_d  = d_base_q;
      k_d       = k_q;
      wr_data_d = wr_data_q;
      flags_d   = flags_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d     = cmd_op;
               vsi_d    = (cmd_vsi == 2'd3) ? VSI_VI : cmd_vsi;
               srcbi_d  = (int'(cmd_srcbi) >= LANES) ? 3'd0 : cmd_srcbi;
               imm_d    = cmd_imm;
               len_d    = len_sat;
               a_base_d = cmd_a_base;
               b_base_d = cmd_b_base;
               d_base_d = cmd_d_base;
               k_d      = '0;
               flags_d  = '0;
               state_d  = (len_sat == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ:  state_d = ST_EXEC;
         ST_EXEC: begin
            wr_data_d = alu_result;
            flags_d   = flags_q | flag_or;
            state_d   = ST_WRITE;
         end
         ST_WRITE: begin
            if (last_chunk) begin
               state_d = ST_DONE;
            end else begin
               k_d     = k_q + KW'(1);
               state_d = ST_READ;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         vsi_q     <= '0;
         srcbi_q   <= '0;
         imm_q     <= '0;
         len_q     <= '0;
         a_base_q  <= '0;
         b_base_q  <= '0;
         d_base_q  <= '0;
         k_q       <= '0;
         wr_data_q <= '0;
         flags_q   <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         vsi_q     <= vsi_d;
         srcbi_q   <= srcbi_d;
         imm_q     <= imm_d;
         len_q     <= len_d;
         a_base_q  <= a_base_d;
         b_base_q  <= b_base_d;
         d_base_q  <= d_base_d;
         k_q       <= k_d;
         wr_data_q <= wr_data_d;
         flags_q   <= flags_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign rd_en     = (state_q == ST_READ);
   assign wr_en     = (state_q == ST_WRITE);

   assign rd_a_addr = chunk_addr(a_base_q, k_q);
   assign rd_b_addr = chunk_addr(b_base_q, k_q);
   assign wr_addr   = chunk_addr(d_base_q, k_q);
   assign wr_mask   = wr_en ? lane_mask : '0;
   assign wr_data   = wr_data_q;
   assign flags_acc = flags_q;

   assign alu_op    = op_q;
   assign alu_vsi   = vsi_q;
   assign alu_srcbi = srcbi_q;
   assign alu_imm   = imm_q;
   assign alu_srca  = rd_a_data;
   assign alu_srcb  = rd_b_data;

endmodule
